// File: rtl/decode_skid_stage.sv
// Elastic MIPS decode stage: a 2-entry skid buffer of {pc, instr} with
// valid/ready on both sides and flush; all decoded fields come from the head entry.
module decode_skid_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [5:0]      out_opcode,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_shamt,
    output logic [5:0]      out_funct,
    output logic [15:0]     out_imm16,
    output logic [XLEN-1:0] out_imm_sext,
    output logic [XLEN-1:0] out_imm_zext,
    output logic [25:0]     out_target,
    output logic [PC_W-1:0] out_jump_addr,
    output logic [1:0]      out_fmt,
    output logic [1:0]      out_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
    logic [31:0]       head_instr_q, head_instr_d, tail_instr_q, tail_instr_d;
    logic              push_s, pop_s;

    assign in_ready  = (state_q != ST_FULL) & ~rst;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_count = state_q;
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;

    // Next-state and buffer-entry steering; flush overrides any push or pop.
    always_comb begin
        state_d      = state_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        tail_pc_d    = tail_pc_q;
        tail_instr_d = tail_instr_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push_s) begin
                        head_pc_d    = in_pc;
                        head_instr_d = in_instr;
                        state_d      = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        head_pc_d    = in_pc;
                        head_instr_d = in_instr;
                        state_d      = ST_ONE;
                    end else if (push_s) begin
                        tail_pc_d    = in_pc;
                        tail_instr_d = in_instr;
                        state_d      = ST_FULL;
                    end else if (pop_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (pop_s) begin
                        head_pc_d    = tail_pc_q;
                        head_instr_d = tail_instr_q;
                        state_d      = ST_ONE;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State and entry registers with synchronous reset to all-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            head_pc_q    <= {PC_W{1'b0}};
            head_instr_q <= 32'd0;
            tail_pc_q    <= {PC_W{1'b0}};
            tail_instr_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            tail_pc_q    <= tail_pc_d;
            tail_instr_q <= tail_instr_d;
        end
    end

    assign out_pc       = head_pc_q;
    assign out_opcode   = head_instr_q[31:26];
    assign out_rs       = head_instr_q[25:21];
    assign out_rt       = head_instr_q[20:16];
    assign out_rd       = head_instr_q[15:11];
    assign out_shamt    = head_instr_q[10:6];
    assign out_funct    = head_instr_q[5:0];
    assign out_imm16    = head_instr_q[15:0];
    assign out_imm_sext = XLEN'($signed(head_instr_q[15:0]));
    assign out_imm_zext = XLEN'(head_instr_q[15:0]);
    assign out_target   = head_instr_q[25:0];

    // Only the region bits of pc+4 matter: they carry in when pc[27:2] is all ones.
    generate
        if (PC_W > 28) begin : g_region
            logic [PC_W-29:0] region_s;
            assign region_s      = head_pc_q[PC_W-1:28] + (PC_W-28)'(&head_pc_q[27:2]);
            assign out_jump_addr = {region_s, head_instr_q[25:0], 2'b00};
        end else begin : g_no_region
            assign out_jump_addr = {head_instr_q[25:0], 2'b00};
        end
    endgenerate

    // Instruction format class from the opcode.
    always_comb begin
        case (head_instr_q[31:26])
            6'd0:       out_fmt = 2'd0;
            6'd2, 6'd3: out_fmt = 2'd1;
            default:    out_fmt = 2'd2;
        endcase
    end

endmodule

// File: tb/tb_decode_skid_stage.sv
// Scoreboard bench for decode_skid_stage: directed instruction vectors with
// hand-computed decode results, checked by an independent output monitor.
module tb_decode_skid_stage;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [31:0] sext, zext;
        logic [25:0] tgt;
        logic [31:0] jmp;
        logic [1:0]  fmt;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = 32'd0, in_pc = 32'd0;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_imm_sext, out_imm_zext, out_jump_addr;
    logic [5:0]  out_opcode, out_funct;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
    logic [15:0] out_imm16;
    logic [25:0] out_target;
    logic [1:0]  out_fmt, out_count;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs [6];
    vec_t exp_q [$];
    vec_t mon_e;

    decode_skid_stage #(.XLEN(32), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .out_funct(out_funct), .out_imm16(out_imm16),
        .out_imm_sext(out_imm_sext), .out_imm_zext(out_imm_zext), .out_target(out_target),
        .out_jump_addr(out_jump_addr), .out_fmt(out_fmt), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every real pop must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got pc 0x%08h expected no output", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pc",     out_pc,             mon_e.pc);
                chk("opcode", 32'(out_opcode),    32'(mon_e.op));
                chk("rs",     32'(out_rs),        32'(mon_e.rs));
                chk("rt",     32'(out_rt),        32'(mon_e.rt));
                chk("rd",     32'(out_rd),        32'(mon_e.rd));
                chk("shamt",  32'(out_shamt),     32'(mon_e.sh));
                chk("funct",  32'(out_funct),     32'(mon_e.fn));
                chk("imm16",  32'(out_imm16),     32'(mon_e.imm));
                chk("sext",   out_imm_sext,       mon_e.sext);
                chk("zext",   out_imm_zext,       mon_e.zext);
                chk("target", 32'(out_target),    32'(mon_e.tgt));
                chk("jump",   out_jump_addr,      mon_e.jmp);
                chk("fmt",    32'(out_fmt),       32'(mon_e.fmt));
            end
        end
    end

    task automatic send(input int idx);
        int guard;
        guard    = 0;
        in_instr = vecs[idx].instr;
        in_pc    = vecs[idx].pc;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("send_timeout", 32'(in_ready), 32'd1);
        end else begin
            exp_q.push_back(vecs[idx]);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_count"},    32'(out_count), 32'd0);
        chk({tag, "_valid"},    32'(out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready),  32'd1);
    endtask

    task automatic check_zero_data(input string tag);
        chk({tag, "_pc"},   out_pc, 32'd0);
        chk({tag, "_dec"},  {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct}, 32'd0);
        chk({tag, "_imm"},  32'(out_imm16), 32'd0);
        chk({tag, "_sext"}, out_imm_sext, 32'd0);
        chk({tag, "_zext"}, out_imm_zext, 32'd0);
        chk({tag, "_tgt"},  32'(out_target), 32'd0);
        chk({tag, "_jump"}, out_jump_addr, 32'd0);
        chk({tag, "_fmt"},  32'(out_fmt), 32'd0);
    endtask

    initial begin
        vecs[0] = '{instr:32'h00221820, pc:32'h00400000, op:6'd0,  rs:5'd1,  rt:5'd2,  rd:5'd3,
                    sh:5'd0,  fn:6'h20, imm:16'h1820, sext:32'h00001820, zext:32'h00001820,
                    tgt:26'h0221820, jmp:32'h00886080, fmt:2'd0};
        vecs[1] = '{instr:32'h2008FFFF, pc:32'h00400004, op:6'd8,  rs:5'd0,  rt:5'd8,  rd:5'd31,
                    sh:5'd31, fn:6'h3F, imm:16'hFFFF, sext:32'hFFFFFFFF, zext:32'h0000FFFF,
                    tgt:26'h008FFFF, jmp:32'h0023FFFC, fmt:2'd2};
        vecs[2] = '{instr:32'h3C017FFF, pc:32'h00400008, op:6'd15, rs:5'd0,  rt:5'd1,  rd:5'd15,
                    sh:5'd31, fn:6'h3F, imm:16'h7FFF, sext:32'h00007FFF, zext:32'h00007FFF,
                    tgt:26'h0017FFF, jmp:32'h0005FFFC, fmt:2'd2};
        vecs[3] = '{instr:32'h08000010, pc:32'h00400000, op:6'd2,  rs:5'd0,  rt:5'd0,  rd:5'd0,
                    sh:5'd0,  fn:6'h10, imm:16'h0010, sext:32'h00000010, zext:32'h00000010,
                    tgt:26'h0000010, jmp:32'h00000040, fmt:2'd1};
        vecs[4] = '{instr:32'h0FFFFFFF, pc:32'hF0000000, op:6'd3,  rs:5'd31, rt:5'd31, rd:5'd31,
                    sh:5'd31, fn:6'h3F, imm:16'hFFFF, sext:32'hFFFFFFFF, zext:32'h0000FFFF,
                    tgt:26'h3FFFFFF, jmp:32'hFFFFFFFC, fmt:2'd1};
        vecs[5] = '{instr:32'h0C000001, pc:32'hFFFFFFFC, op:6'd3,  rs:5'd0,  rt:5'd0,  rd:5'd0,
                    sh:5'd0,  fn:6'h01, imm:16'h0001, sext:32'h00000001, zext:32'h00000001,
                    tgt:26'h0000001, jmp:32'h00000004, fmt:2'd1};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("reset");
        check_zero_data("reset");

        // Single push, then streaming at full rate
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(0);
        @(negedge clk);
        chk("single_count", 32'(out_count), 32'd1);
        chk("single_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        for (int i = 1; i < 6; i++) send(i);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("stream_drained", 32'(out_count), 32'd0);

        // Backpressure: A and B fill the buffer, C waits for the first pop
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(0);
        send(1);
        @(negedge clk);
        chk("bp_full_count", 32'(out_count), 32'd2);
        chk("bp_full_ready", 32'(in_ready),  32'd0);
        chk("bp_head_pc",    out_pc,         vecs[0].pc);
        in_instr = vecs[2].instr;
        in_pc    = vecs[2].pc;
        in_valid = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_c_held_ready", 32'(in_ready),  32'd0);
        chk("bp_c_held_count", 32'(out_count), 32'd2);
        chk("bp_head_stable",  out_pc,         vecs[0].pc);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_ready_rise", 32'(in_ready),  32'd1);
        chk("bp_after_pop",  32'(out_count), 32'd1);
        exp_q.push_back(vecs[2]);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_c_only", 32'(out_count), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_drained", 32'(out_count), 32'd0);

        // Flush while full with a simultaneous push offer
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(3);
        send(4);
        in_instr = vecs[5].instr;
        in_pc    = vecs[5].pc;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_idle("flush");
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(0);
        repeat (3) @(posedge clk);
        #1;

        // Reset while full with the consumer ready
        out_ready = 1'b0;
        send(1);
        send(2);
        out_ready = 1'b1;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_idle("midrst");
        check_zero_data("midrst");
        @(posedge clk);
        #1;
        send(4);
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 32'd1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
